// File: rtl/cnn_seq_pkg.sv
// rtl/cnn_seq_pkg.sv - shared state type, fill pattern and address helper for the conv input sequencer
package cnn_seq_pkg;

  typedef enum logic [2:0] {
    IDLE          = 3'd0,
    PRIME         = 3'd1,
    LOAD          = 3'd2,
    STREAM        = 3'd3,
    WAIT_NOT_HOLD = 3'd4,
    DONE          = 3'd5
  } seq_state_t;

  localparam logic [31:0] PIXEL_FILL = 32'habababab;

  // First RAM word of channel c in the channel-major image.
  function automatic int unsigned channel_base(input int unsigned c,
                                               input int unsigned rows,
                                               input int unsigned cols);
    return c * rows * cols;
  endfunction

endpackage

// File: rtl/seq_round_robin.sv
// rtl/seq_round_robin.sv - active channel register plus next non-exhausted channel search
// The search starts one past the current channel and may land back on it.
module seq_round_robin #(
  parameter  int N_CHANNELS = 3,
  localparam int CH_W       = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  clear_i,
  input  logic                  advance_i,
  input  logic [N_CHANNELS-1:0] exhausted_i,
  output logic [CH_W-1:0]       ch_o,
  output logic [CH_W-1:0]       next_o,
  output logic                  all_exhausted_o
);

  logic [CH_W-1:0] ch_q;
  logic [CH_W:0]   idx;
  logic            found;

  always_comb begin
    next_o = ch_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= N_CHANNELS; k++) begin
      idx = {1'b0, ch_q} + (CH_W+1)'(k);
      if (idx >= (CH_W+1)'(N_CHANNELS)) idx = idx - (CH_W+1)'(N_CHANNELS);
      if (!found && !exhausted_i[idx[CH_W-1:0]]) begin
        next_o = idx[CH_W-1:0];
        found  = 1'b1;
      end
    end
  end

  assign all_exhausted_o = &exhausted_i;
  assign ch_o            = ch_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)        ch_q <= '0;
    else if (clear_i)   ch_q <= '0;
    else if (advance_i) ch_q <= next_o;
  end

endmodule

// File: rtl/conv_input_sequencer.sv
// rtl/conv_input_sequencer.sv - streams a channel-major image from RAM to the conv core, one channel at a time
// Optional SEQ_PERF_COUNTERS_EN adds stall and hold-switch counters.
module conv_input_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int N_ROWS     = 28,
  parameter int N_COLS     = 28,
  parameter int N_CHANNELS = 3
) (
  input  logic                                  clock_i,
  input  logic                                  reset_i,
  input  logic                                  start_i,
  input  logic [DATA_WIDTH-1:0]                 ram_data_i,
  input  logic [N_CHANNELS-1:0]                 hold_data_i,
  output logic [ADDR_WIDTH-1:0]                 ram_rdaddress_o,
  output logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] data_o,
  output logic [N_CHANNELS-1:0]                 data_valid_o,
  output logic                                  busy_o,
  output logic                                  done_o
`ifdef SEQ_PERF_COUNTERS_EN
  ,
  output logic [31:0]                           stall_cycles_o,
  output logic [15:0]                           switch_count_o
`endif
);

  localparam int N_PIX = N_ROWS * N_COLS;
  localparam int PTR_W = $clog2(N_PIX + 1);
  localparam int CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam logic [PTR_W-1:0]      N_PIX_P = PTR_W'(N_PIX);
  localparam logic [DATA_WIDTH-1:0] FILL    = DATA_WIDTH'(PIXEL_FILL);

  if (N_CHANNELS < 1 ||
      longint'(N_CHANNELS) * N_ROWS * N_COLS > (longint'(1) << ADDR_WIDTH)) begin : g_param_check
    $error("conv_input_sequencer: image does not fit in ADDR_WIDTH or N_CHANNELS < 1");
  end

  seq_state_t                            state_q;
  logic [ADDR_WIDTH-1:0]                 addr_q;
  logic [N_CHANNELS-1:0][PTR_W-1:0]      ptr_q;
  logic [N_CHANNELS-1:0]                 exhausted_q;
  logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] data_q;
  logic [N_CHANNELS-1:0]                 valid_q;
  logic                                  busy_q;
  logic                                  done_q;

  logic [CH_W-1:0]       ch, next_ch, sel_ch;
  logic [PTR_W-1:0]      cur_ptr;
  logic                  cur_hold, next_hold, all_exh;
  logic                  start_accept, hold_switch, last_consume, advance;
  logic [N_CHANNELS-1:0] rr_mask;
  logic [ADDR_WIDTH-1:0] resume_addr;

  assign start_accept = (state_q == IDLE) && start_i;
  assign cur_hold     = hold_data_i[ch];
  assign cur_ptr      = ptr_q[ch];
  assign next_hold    = hold_data_i[next_ch];
  assign hold_switch  = (state_q == STREAM) && cur_hold;
  assign last_consume = (state_q == STREAM) && !cur_hold && (cur_ptr == N_PIX_P);
  // The channel finishing this edge must already count as exhausted for the search.
  assign rr_mask      = exhausted_q | (last_consume ? (N_CHANNELS'(1) << ch) : '0);
  assign advance      = hold_switch || (last_consume && !all_exh);

  seq_round_robin #(.N_CHANNELS(N_CHANNELS)) u_rr (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .clear_i         (start_accept),
    .advance_i       (advance),
    .exhausted_i     (rr_mask),
    .ch_o            (ch),
    .next_o          (next_ch),
    .all_exhausted_o (all_exh)
  );

  assign sel_ch      = (state_q == WAIT_NOT_HOLD) ? ch : next_ch;
  assign resume_addr = ADDR_WIDTH'(channel_base(32'(sel_ch), N_ROWS, N_COLS))
                     + ADDR_WIDTH'(ptr_q[sel_ch]);

  // The address runs one word ahead of data_o so RAM latency is hidden while streaming.
  // A switch to a channel whose hold is already low skips the wait state, keeping
  // the switch cost at PRIME plus LOAD.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      ptr_q       <= '0;
      exhausted_q <= '0;
      data_q      <= {N_CHANNELS{FILL}};
      valid_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          busy_q      <= 1'b1;
          ptr_q       <= '0;
          exhausted_q <= '0;
          addr_q      <= '0;
          state_q     <= PRIME;
        end
        PRIME: begin
          addr_q  <= addr_q + ADDR_WIDTH'(1);
          state_q <= LOAD;
        end
        LOAD: begin
          data_q[ch]  <= ram_data_i;
          ptr_q[ch]   <= cur_ptr + PTR_W'(1);
          addr_q      <= addr_q + ADDR_WIDTH'(1);
          valid_q[ch] <= 1'b1;
          state_q     <= STREAM;
        end
        STREAM: begin
          if (cur_hold) begin
            valid_q[ch] <= 1'b0;
            ptr_q[ch]   <= cur_ptr - PTR_W'(1);
            state_q     <= next_hold ? WAIT_NOT_HOLD : PRIME;
            if (!next_hold) addr_q <= resume_addr;
          end else if (cur_ptr == N_PIX_P) begin
            valid_q[ch]     <= 1'b0;
            exhausted_q[ch] <= 1'b1;
            if (all_exh) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= next_hold ? WAIT_NOT_HOLD : PRIME;
              if (!next_hold) addr_q <= resume_addr;
            end
          end else begin
            data_q[ch] <= ram_data_i;
            ptr_q[ch]  <= cur_ptr + PTR_W'(1);
            addr_q     <= addr_q + ADDR_WIDTH'(1);
          end
        end
        WAIT_NOT_HOLD: if (!cur_hold) begin
          addr_q  <= resume_addr;
          state_q <= PRIME;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ram_rdaddress_o = addr_q;
  assign data_o          = data_q;
  assign data_valid_o    = valid_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] stall_q;
  logic [15:0] switch_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      stall_q  <= '0;
      switch_q <= '0;
    end else if (start_accept) begin
      stall_q  <= '0;
      switch_q <= '0;
    end else begin
      if (busy_q && (valid_q == '0) && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (hold_switch && (switch_q != '1))              switch_q <= switch_q + 16'd1;
    end
  end

  assign stall_cycles_o = stall_q;
  assign switch_count_o = switch_q;
`endif

endmodule

// File: tb/tb_conv_input_sequencer.sv
// tb/tb_conv_input_sequencer.sv - scoreboard bench for conv_input_sequencer, 4x4 image, 3 channels, RAM word = address
module tb_conv_input_sequencer;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int NCH = 3;

  typedef struct packed {
    logic [7:0]    ch;
    logic [DW-1:0] px;
  } exp_t;

  logic                    clk   = 1'b0;
  logic                    rst   = 1'b1;
  logic                    start = 1'b0;
  logic [DW-1:0]           ram_q = '0;
  logic [NCH-1:0]          hold  = '0;
  logic [AW-1:0]           addr;
  logic [NCH-1:0][DW-1:0]  data;
  logic [NCH-1:0]          dv;
  logic                    busy, done;
`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0]             stall;
  logic [15:0]             sw;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];

  conv_input_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_ROWS(4), .N_COLS(4), .N_CHANNELS(NCH)
  ) dut (
    .clock_i         (clk),
    .reset_i         (rst),
    .start_i         (start),
    .ram_data_i      (ram_q),
    .hold_data_i     (hold),
    .ram_rdaddress_o (addr),
    .data_o          (data),
    .data_valid_o    (dv),
    .busy_o          (busy),
    .done_o          (done)
`ifdef SEQ_PERF_COUNTERS_EN
    ,
    .stall_cycles_o  (stall),
    .switch_count_o  (sw)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= {16'h0, addr};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a pixel is consumed at the coming edge when valid and not held.
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      check("valid_onehot0", 64'($onehot0(dv)), 64'(1));
      for (int c = 0; c < NCH; c++) begin
        if (dv[c] && !hold[c]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pixel", 64'({8'(c), data[c]}), 64'hFFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("pixel", 64'({8'(c), data[c]}), 64'({e.ch, e.px}));
          end
        end
      end
      if (done) begin
        done_cnt++;
        check("done_after_all_consumed", 64'(exp_q.size()), 64'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int ch, input int lo, input int hi);
    for (int v = lo; v <= hi; v++) exp_q.push_back({8'(ch), DW'(v)});
  endtask

  task automatic push_frame();
    push_range(0, 0, 15);
    push_range(1, 16, 31);
    push_range(2, 32, 47);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_pixel(input string name, input int ch, input int val);
    int n = 0;
    while (!(dv[ch] && data[ch] == DW'(val)) && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) check({name, "_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < 1000) begin
      tick();
      n++;
    end
    repeat (5) tick();
    check({name, "_done_count"}, 64'(done_cnt - d0), 64'(1));
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
    check({name, "_busy_low"}, 64'(busy), 64'(0));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_addr"}, 64'(addr), 64'(0));
    check({name, "_valid"}, 64'(dv), 64'(0));
    check({name, "_busy"}, 64'(busy), 64'(0));
    check({name, "_done"}, 64'(done), 64'(0));
    for (int c = 0; c < NCH; c++) check({name, "_data"}, 64'(data[c]), 64'h0000_0000_abab_abab);
  endtask

  initial begin
    logic [AW-1:0] a0;
    int            d0;

    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Plain frame; a second start mid-stream must be ignored.
    push_frame();
    pulse_start();
    check("busy_after_start", 64'(busy), 64'(1));
    wait_pixel("t1_px8", 0, 8);
    pulse_start();
    check("busy_while_streaming", 64'(busy), 64'(1));
    wait_done("t1");
`ifdef SEQ_PERF_COUNTERS_EN
    check("t1_stall", 64'(stall), 64'(7));
    check("t1_switch", 64'(sw), 64'(0));
`endif

    // One-cycle hold on ch0 while pixel 5 is shown.
    push_range(0, 0, 4);
    push_range(1, 16, 31);
    push_range(2, 32, 47);
    push_range(0, 5, 15);
    pulse_start();
    wait_pixel("t2_px5", 0, 5);
    hold[0] = 1'b1;
    tick();
    hold[0] = 1'b0;
    check("t2_prime_no_valid", 64'(dv), 64'(0));
    tick();
    check("t2_load_no_valid", 64'(dv), 64'(0));
    tick();
    check("t2_ch1_first", 64'({dv, data[1]}), 64'({3'b010, 32'd16}));
    wait_done("t2");
`ifdef SEQ_PERF_COUNTERS_EN
    check("t2_stall", 64'(stall), 64'(9));
    check("t2_switch", 64'(sw), 64'(1));
`endif

    // Every channel held for 10 cycles: nothing valid, address frozen.
    push_range(0, 0, 2);
    push_range(1, 16, 31);
    push_range(2, 32, 47);
    push_range(0, 3, 15);
    pulse_start();
    wait_pixel("t3_px3", 0, 3);
    hold = '1;
    tick();
    a0 = addr;
    check("t3_hold_valid", 64'(dv), 64'(0));
    for (int i = 0; i < 9; i++) begin
      tick();
      check("t3_hold_valid", 64'(dv), 64'(0));
      check("t3_addr_frozen", 64'(addr), 64'(a0));
    end
    hold = '0;
    wait_done("t3");

    // Hold on the very last pixel: it is re-presented before done.
    push_frame();
    pulse_start();
    wait_pixel("t4_px47", 2, 47);
    hold[2] = 1'b1;
    tick();
    hold[2] = 1'b0;
    check("t4_no_done_on_hold", 64'({dv, done}), 64'(0));
    wait_done("t4");

    // Reset mid-stream aborts without done, then a fresh frame runs.
    push_frame();
    pulse_start();
    wait_pixel("t5_px7", 0, 7);
    d0  = done_cnt;
    rst = 1'b1;
    #1;
    check_reset_outputs("t5_midreset");
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("t5_no_done_after_abort", 64'(done_cnt - d0), 64'(0));
    push_frame();
    pulse_start();
    wait_done("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
